// File: rtl/ika87ad_opfetch.sv
// IKA87AD opcode fetch sequencer: byte-read handshake, prefix paging
// and hardware-interrupt pseudo-opcode injection toward the decoder.
module ika87ad_opfetch (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_MCUCLK_PCEN,
  input  logic       i_FETCH_REQ,
  input  logic       i_INT_REQ,
  output logic       o_INT_ACK,
  output logic       o_OPRD_REQ,
  output logic       o_M1,
  input  logic       i_OPRD_ACK,
  input  logic [7:0] i_OPRD_DATA,
  output logic       o_PC_INC,
  output logic [7:0] o_OPCODE,
  output logic [2:0] o_OPCODE_PAGE,
  output logic       o_DISP_VALID,
  input  logic       i_DISP_ACK,
  output logic       o_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_GAP,
    S_RD2,
    S_DISP
  } state_t;

  state_t     r_state;
  state_t     w_nxt;
  logic [7:0] r_opcode;
  logic [7:0] w_opcode;
  logic [2:0] r_page;
  logic [2:0] w_page;
  logic       r_pc_inc;
  logic       w_pc_inc;
  logic       r_int_ack;
  logic       w_int_ack;
  logic [2:0] w_pfx_pg;
  logic       w_start;

  // Prefix byte to page map; zero means not a prefix
  always_comb begin
    w_pfx_pg = 3'd0;
    case (i_OPRD_DATA)
      8'h48:   w_pfx_pg = 3'd1;
      8'h60:   w_pfx_pg = 3'd2;
      8'h64:   w_pfx_pg = 3'd3;
      8'h70:   w_pfx_pg = 3'd4;
      8'h74:   w_pfx_pg = 3'd5;
      default: w_pfx_pg = 3'd0;
    endcase
  end

  always_comb begin
    w_nxt     = r_state;
    w_opcode  = r_opcode;
    w_page    = r_page;
    w_pc_inc  = 1'b0;
    w_int_ack = 1'b0;
    w_start   = 1'b0;
    unique case (r_state)
      S_IDLE: w_start = 1'b1;
      S_DISP: begin
        if (i_DISP_ACK) begin
          w_nxt   = S_IDLE;
          w_start = 1'b1;
        end
      end
      S_RD1: begin
        if (i_OPRD_ACK) begin
          w_pc_inc = 1'b1;
          if (w_pfx_pg != 3'd0) begin
            w_page = w_pfx_pg;
            w_nxt  = S_GAP;
          end else begin
            w_opcode = i_OPRD_DATA;
            w_page   = 3'd0;
            w_nxt    = S_DISP;
          end
        end
      end
      S_GAP: w_nxt = S_RD2;
      S_RD2: begin
        if (i_OPRD_ACK) begin
          w_pc_inc = 1'b1;
          w_opcode = i_OPRD_DATA;
          w_nxt    = S_DISP;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    // Decision point shared by IDLE and a dispatch taken back-to-back
    if (w_start && i_FETCH_REQ) begin
      if (i_INT_REQ) begin
        w_opcode  = 8'h73;
        w_page    = 3'd0;
        w_int_ack = 1'b1;
        w_nxt     = S_DISP;
      end else begin
        w_nxt = S_RD1;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_state   <= S_IDLE;
      r_opcode  <= 8'h00;
      r_page    <= 3'd0;
      r_pc_inc  <= 1'b0;
      r_int_ack <= 1'b0;
    end else if (i_MCUCLK_PCEN) begin
      r_state   <= w_nxt;
      r_opcode  <= w_opcode;
      r_page    <= w_page;
      r_pc_inc  <= w_pc_inc;
      r_int_ack <= w_int_ack;
    end
  end

  assign o_OPRD_REQ    = (r_state == S_RD1) || (r_state == S_RD2);
  assign o_M1          = (r_state == S_RD1);
  assign o_DISP_VALID  = (r_state == S_DISP);
  assign o_BUSY        = (r_state != S_IDLE);
  assign o_OPCODE      = r_opcode;
  assign o_OPCODE_PAGE = r_page;
  assign o_PC_INC      = r_pc_inc;
  assign o_INT_ACK     = r_int_ack;

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Bench for ika87ad_opfetch: directed fetches, bus responder and a
// dispatch scoreboard checked by an independent monitor.
module tb_ika87ad_opfetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcen = 1'b1;
  logic       fetch = 1'b0;
  logic       intr = 1'b0;
  logic       ack = 1'b0;
  logic       dack = 1'b0;
  logic [7:0] data = 8'h00;
  logic       o_INT_ACK, o_OPRD_REQ, o_M1, o_PC_INC;
  logic       o_DISP_VALID, o_BUSY;
  logic [7:0] o_OPCODE;
  logic [2:0] o_OPCODE_PAGE;

  always #5 clk = ~clk;

  ika87ad_opfetch dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_MCUCLK_PCEN (pcen),
    .i_FETCH_REQ   (fetch),
    .i_INT_REQ     (intr),
    .o_INT_ACK     (o_INT_ACK),
    .o_OPRD_REQ    (o_OPRD_REQ),
    .o_M1          (o_M1),
    .i_OPRD_ACK    (ack),
    .i_OPRD_DATA   (data),
    .o_PC_INC      (o_PC_INC),
    .o_OPCODE      (o_OPCODE),
    .o_OPCODE_PAGE (o_OPCODE_PAGE),
    .o_DISP_VALID  (o_DISP_VALID),
    .i_DISP_ACK    (dack),
    .o_BUSY        (o_BUSY)
  );

  typedef struct {
    logic [7:0] op;
    logic [2:0] pg;
    int npc;
    int nint;
    int nack;
    int nm1;
    int ngap;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int pmode = 0;
  int cyc = 0;
  int bwait = 0;
  int wcnt = 0;
  bit last_en = 1'b0;
  bit stray = 1'b0;
  logic [7:0] bq[$];
  exp_t sb[$];
  exp_t m_e;
  int c_pc = 0, c_int = 0, c_ack = 0, c_m1 = 0, c_gap = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] op, input logic [2:0] pg,
                              input int a, input int b, input int c,
                              input int d, input int f);
    exp_t e;
    e.op = op; e.pg = pg; e.npc = a; e.nint = b;
    e.nack = c; e.nm1 = d; e.ngap = f;
    return e;
  endfunction

  // One clock: advance, then drive enable and the bus responder
  task automatic step();
    bit cons;
    cons = ack && o_OPRD_REQ && pcen && !rst;
    last_en = pcen && !rst;
    @(posedge clk);
    #1;
    if (cons && bq.size() > 0) begin
      bq.delete(0);
      wcnt = 0;
    end
    pcen = (pmode == 0) || (cyc % 3 == 0);
    cyc++;
    ack = 1'b0;
    if (rst) begin
      bq.delete();
      wcnt = 0;
    end else if (o_OPRD_REQ && bq.size() > 0) begin
      if (wcnt >= bwait) begin
        ack = 1'b1;
        data = bq[0];
      end else if (pcen) begin
        wcnt++;
      end
    end else if (stray && !o_OPRD_REQ) begin
      ack = 1'b1;
      data = 8'h48;
    end
  endtask

  task automatic issue();
    fetch = 1'b1;
    do step(); while (!last_en);
    fetch = 1'b0;
  endtask

  task automatic take();
    dack = 1'b1;
    do step(); while (!last_en);
    dack = 1'b0;
  endtask

  task automatic wait_disp();
    for (int i = 0; i < 300 && !o_DISP_VALID; i++) step();
    chk("disp_wait", int'(o_DISP_VALID), 1);
  endtask

  task automatic wait_gap();
    for (int i = 0; i < 300 && !(o_BUSY && !o_OPRD_REQ && !o_DISP_VALID); i++)
      step();
    chk("gap_wait", int'(o_BUSY && !o_OPRD_REQ), 1);
  endtask

  task automatic wait_rd2();
    for (int i = 0; i < 300 && !(o_OPRD_REQ && !o_M1); i++) step();
    chk("rd2_wait", int'(o_OPRD_REQ && !o_M1), 1);
  endtask

  task automatic run(input logic [7:0] b0, input logic [7:0] b1,
                     input bit pre, input int w,
                     input logic [7:0] eop, input logic [2:0] epg);
    bwait = w;
    bq.push_back(b0);
    if (pre) bq.push_back(b1);
    if (pre) sb.push_back(mk(eop, epg, 2, 0, 2, 1, 1));
    else     sb.push_back(mk(eop, epg, 1, 0, 1, 1, 0));
    issue();
    wait_disp();
    take();
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req"},  int'(o_OPRD_REQ), 0);
    chk({nm, "_m1"},   int'(o_M1), 0);
    chk({nm, "_pc"},   int'(o_PC_INC), 0);
    chk({nm, "_iack"}, int'(o_INT_ACK), 0);
    chk({nm, "_dv"},   int'(o_DISP_VALID), 0);
    chk({nm, "_busy"}, int'(o_BUSY), 0);
    chk({nm, "_op"},   int'(o_OPCODE), 0);
    chk({nm, "_pg"},   int'(o_OPCODE_PAGE), 0);
  endtask

  // Monitor: tallies per-instruction activity, scores each dispatch taken
  always @(negedge clk) begin
    if (rst) begin
      c_pc = 0; c_int = 0; c_ack = 0; c_m1 = 0; c_gap = 0;
    end else if (pcen) begin
      if (o_PC_INC) c_pc++;
      if (o_INT_ACK) c_int++;
      if (o_OPRD_REQ && ack) begin
        c_ack++;
        if (o_M1) c_m1++;
      end
      if (o_BUSY && !o_OPRD_REQ && !o_DISP_VALID) c_gap++;
      if (o_DISP_VALID && dack) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", sb.size(), 1);
        end else begin
          m_e = sb.pop_front();
          chk("sb_op",   int'(o_OPCODE), int'(m_e.op));
          chk("sb_pg",   int'(o_OPCODE_PAGE), int'(m_e.pg));
          chk("sb_pcinc", c_pc, m_e.npc);
          chk("sb_intack", c_int, m_e.nint);
          chk("sb_bytes", c_ack, m_e.nack);
          chk("sb_m1", c_m1, m_e.nm1);
          chk("sb_gap", c_gap, m_e.ngap);
        end
        c_pc = 0; c_int = 0; c_ack = 0; c_m1 = 0; c_gap = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b0;
    step();
    step();

    // Single byte, zero wait: REQ/M1 next cycle, DISP the one after
    bwait = 0;
    bq.push_back(8'h54);
    sb.push_back(mk(8'h54, 3'd0, 1, 0, 1, 1, 0));
    issue();
    chk("a_req", int'(o_OPRD_REQ), 1);
    chk("a_m1", int'(o_M1), 1);
    step();
    chk("a_dv", int'(o_DISP_VALID), 1);
    chk("a_pcinc", int'(o_PC_INC), 1);
    chk("a_m1_low", int'(o_M1), 0);
    take();

    run(8'h70, 8'h6A, 1, 3, 8'h6A, 3'd4);
    run(8'h48, 8'h48, 1, 0, 8'h48, 3'd1);
    run(8'h60, 8'h60, 1, 0, 8'h60, 3'd2);
    run(8'h64, 8'h64, 1, 1, 8'h64, 3'd3);
    run(8'h74, 8'h74, 1, 0, 8'h74, 3'd5);

    // Interrupt injection
    intr = 1'b1;
    sb.push_back(mk(8'h73, 3'd0, 0, 1, 0, 0, 0));
    issue();
    chk("int_dv", int'(o_DISP_VALID), 1);
    chk("int_ack", int'(o_INT_ACK), 1);
    chk("int_req", int'(o_OPRD_REQ), 0);
    chk("int_op", int'(o_OPCODE), 8'h73);
    take();
    intr = 1'b0;

    // Interrupt arriving mid-fetch leaves the fetch alone
    bwait = 2;
    bq.push_back(8'h64);
    bq.push_back(8'h12);
    sb.push_back(mk(8'h12, 3'd3, 2, 0, 2, 1, 1));
    issue();
    wait_rd2();
    intr = 1'b1;
    wait_disp();
    chk("midint_iack", int'(o_INT_ACK), 0);
    take();
    intr = 1'b0;

    // Stray bus acks while idle are ignored
    stray = 1'b1;
    repeat (3) step();
    stray = 1'b0;
    chk("stray_busy", int'(o_BUSY), 0);
    chk("stray_pc", int'(o_PC_INC), 0);

    // Back-to-back dispatch and fetch
    bwait = 0;
    bq.push_back(8'h54);
    bq.push_back(8'h33);
    sb.push_back(mk(8'h54, 3'd0, 1, 0, 1, 1, 0));
    sb.push_back(mk(8'h33, 3'd0, 1, 0, 1, 1, 0));
    issue();
    wait_disp();
    fetch = 1'b1;
    dack = 1'b1;
    do step(); while (!last_en);
    fetch = 1'b0;
    dack = 1'b0;
    chk("b2b_req", int'(o_OPRD_REQ), 1);
    chk("b2b_m1", int'(o_M1), 1);
    wait_disp();
    take();

    // Clock enable 1-in-3: same results, stretched
    pmode = 1;
    run(8'h54, 8'h00, 0, 0, 8'h54, 3'd0);
    run(8'h70, 8'h6A, 1, 3, 8'h6A, 3'd4);
    intr = 1'b1;
    sb.push_back(mk(8'h73, 3'd0, 0, 1, 0, 0, 0));
    issue();
    wait_disp();
    take();
    intr = 1'b0;
    pmode = 0;
    step();

    // Reset while in GAP
    bwait = 0;
    bq.push_back(8'h60);
    bq.push_back(8'h11);
    issue();
    wait_gap();
    rst = 1'b1;
    #1;
    chk_reset("rstgap");
    step();
    step();
    rst = 1'b0;
    step();
    bq.push_back(8'h54);
    sb.push_back(mk(8'h54, 3'd0, 1, 0, 1, 1, 0));
    issue();
    chk("fresh_m1", int'(o_M1), 1);
    wait_disp();
    take();

    // Reset while a second-byte read is pending
    bwait = 2;
    bq.push_back(8'h74);
    bq.push_back(8'h22);
    issue();
    wait_rd2();
    rst = 1'b1;
    #1;
    chk_reset("rstrd2");
    step();
    rst = 1'b0;
    step();
    bwait = 0;
    run(8'h64, 8'h20, 1, 0, 8'h20, 3'd3);

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
